// File: rtl/uart_rx.sv
// Purpose: UART receiver with 2-flop synchronizer, programmable oversampling, 3-sample majority vote, optional parity.
// Latency: strobe fires PRESCALE*(10+PAR_EN)+1 clocks after the synchronized start-bit falling edge.
// Backpressure: none; strobes are one-cycle pulses and the consumer must accept them when they occur.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_in,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic [DATA_WIDTH-1:0] o_p_data,
  output logic                  o_data_valid,
  output logic                  o_par_err,
  output logic                  o_stp_err,
  output logic                  o_rx_busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;

  logic                    r_sync1;
  logic                    r_rx_s;
  logic [PRESCALE_W-1:0]   r_edge_cnt;
  logic [BIT_W-1:0]        r_bit_cnt;
  logic [PRESCALE_W-1:0]   r_pre;
  logic                    r_par_en;
  logic                    r_par_typ;
  logic [2:0]              r_samp;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic                    r_par_fail;
  logic                    r_stp_fail;

  logic [PRESCALE_W-1:0]   w_half;
  logic [PRESCALE_W-1:0]   w_samp0_at;
  logic [PRESCALE_W-1:0]   w_samp2_at;
  logic [PRESCALE_W-1:0]   w_vote_at;
  logic [PRESCALE_W-1:0]   w_last_at;
  logic                    w_last;
  logic                    w_vote_now;
  logic                    w_bit_last;
  logic                    w_vote;
  logic                    w_par_exp;
  logic                    w_frame_start;
  logic                    w_good;

  // Sample points sit symmetrically around the middle of each bit period.
  assign w_half     = r_pre >> 1;
  assign w_samp0_at = w_half - PRESCALE_W'(1);
  assign w_samp2_at = w_half + PRESCALE_W'(1);
  assign w_vote_at  = w_half + PRESCALE_W'(2);
  assign w_last_at  = r_pre - PRESCALE_W'(1);
  assign w_last     = (r_edge_cnt == w_last_at);
  assign w_vote_now = (r_edge_cnt == w_vote_at);
  assign w_bit_last = (r_bit_cnt == BIT_W'(DATA_WIDTH - 1));

  assign w_vote = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);

  // Odd parity expects the XNOR of the data, even parity the XOR, as the transmitter generates it.
  assign w_par_exp = r_par_typ ? ~^r_shift : ^r_shift;

  // A new frame begins from IDLE, or directly from DONE when the next start bit is already on the line.
  assign w_frame_start = ((r_state == S_IDLE) || (r_state == S_DONE)) && !r_rx_s;

  assign w_good    = !r_par_fail && !r_stp_fail;
  assign o_rx_busy = (r_state != S_IDLE);

  // Bring the asynchronous line into the clock domain; idle level is 1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= i_rx_in;
      r_rx_s  <= r_sync1;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; every bit state ends on the last oversample tick.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (!r_rx_s) w_next = S_START;
      S_START:  if (w_last) w_next = w_vote ? S_IDLE : S_DATA;
      S_DATA:   if (w_last && w_bit_last) w_next = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_last) w_next = S_STOP;
      S_STOP:   if (w_last) w_next = S_DONE;
      S_DONE:   w_next = r_rx_s ? S_IDLE : S_START;
      default:  w_next = S_IDLE;
    endcase
  end

  // Oversample counter; the cycle that detects the start edge is tick 0 of the start bit,
  // so START resumes at tick 1 and a frame spans exactly PRESCALE ticks per bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_edge_cnt <= '0;
    end else if (w_frame_start) begin
      r_edge_cnt <= PRESCALE_W'(1);
    end else if ((r_state == S_IDLE) || (r_state == S_DONE) || w_last) begin
      r_edge_cnt <= '0;
    end else begin
      r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
    end
  end

  // Data bit index, advanced at the end of each data bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_cnt <= '0;
    end else if (r_state != S_DATA) begin
      r_bit_cnt <= '0;
    end else if (w_last) begin
      r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + BIT_W'(1);
    end
  end

  // Capture the three mid-bit samples for the majority vote.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_samp <= '0;
    end else begin
      if (r_edge_cnt == w_samp0_at) r_samp[0] <= r_rx_s;
      if (r_edge_cnt == w_half)     r_samp[1] <= r_rx_s;
      if (r_edge_cnt == w_samp2_at) r_samp[2] <= r_rx_s;
    end
  end

  // Frame configuration latch, data shift-in and error flag collection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre      <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_shift    <= '0;
      r_par_fail <= 1'b0;
      r_stp_fail <= 1'b0;
    end else begin
      if (w_frame_start) begin
        r_pre      <= i_prescale;
        r_par_en   <= i_par_en;
        r_par_typ  <= i_par_typ;
        r_par_fail <= 1'b0;
        r_stp_fail <= 1'b0;
      end
      if (w_vote_now) begin
        case (r_state)
          S_DATA:   r_shift[r_bit_cnt] <= w_vote;
          S_PARITY: if (w_vote != w_par_exp) r_par_fail <= 1'b1;
          S_STOP:   if (!w_vote) r_stp_fail <= 1'b1;
          default:  ;
        endcase
      end
    end
  end

  // Registered result strobes; P_DATA only moves on a clean frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_p_data     <= '0;
      o_data_valid <= 1'b0;
      o_par_err    <= 1'b0;
      o_stp_err    <= 1'b0;
    end else begin
      o_data_valid <= (r_state == S_DONE) && w_good;
      o_par_err    <= (r_state == S_DONE) && r_par_fail;
      o_stp_err    <= (r_state == S_DONE) && r_stp_fail;
      if ((r_state == S_DONE) && w_good) begin
        o_p_data <= r_shift;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the receive-side counterpart of the team's UART transmitter. Frame format is identical.
- Frame: start bit (0), 8 data bits LSB first, optional parity bit, one stop bit (1). Line idles at 1.
- Oversamples RX_IN at a programmable rate and majority-votes each bit.
- Delivers the byte on P_DATA with a one-cycle DATA_VALID strobe, plus parity and stop error flags, to the system controller / RX FIFO.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the PRESCALE port.

Ports:
- CLK  input  1  oversampling clock.
- RST  input  1  reset.
- RX_IN  input  1  asynchronous serial line; idles high.
- PRESCALE  input  PRESCALE_W  CLK cycles per bit; legal values are 8, 16 and 32.
- PAR_EN  input  1  1 means a parity bit is present.
- PAR_TYP  input  1  1 means odd parity, 0 means even parity.
- P_DATA  output  DATA_WIDTH  last correctly received byte.
- DATA_VALID  output  1  one-cycle strobe; P_DATA is new.
- PAR_ERR  output  1  one-cycle strobe; parity mismatch.
- STP_ERR  output  1  one-cycle strobe; stop bit sampled 0.
- RX_BUSY  output  1  high while a frame is being received.
- Interface (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Reset (RST high at a CLK edge):
  - P_DATA = 0; DATA_VALID, PAR_ERR, STP_ERR, RX_BUSY = 0.
  - State goes to IDLE; all counters go to 0; synchronizer flops go to 1.
  - Reset mid-frame aborts the frame silently; no strobes are produced.
- Input synchronizer: RX_IN passes through 2 flops (rx_s). All timing below is relative to rx_s.
- Counters:
  - edge_cnt counts 0..PRESCALE-1 within a bit period.
  - bit_cnt counts 0..DATA_WIDTH-1.
- Sampling:
  - Samples are taken at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - The bit value is the majority of the 3 samples and is valid at edge_cnt = PRESCALE/2+2.
- Configuration latch: PRESCALE, PAR_EN and PAR_TYP are captured on leaving IDLE and held for the whole frame. Changes mid-frame take effect on the next frame.
- State machine: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE: rx_s = 0 moves to START with edge_cnt = 0. RX_BUSY = 0 only in IDLE.
  - START:
    - Voted bit 1 means a glitch: return to IDLE at edge_cnt = PRESCALE-1 with no strobes.
    - Otherwise go to DATA at edge_cnt = PRESCALE-1.
  - DATA:
    - The voted bit is shifted into shift_reg[bit_cnt] (LSB first).
    - At edge_cnt = PRESCALE-1 with bit_cnt = DATA_WIDTH-1, go to PARITY if PAR_EN = 1, else to STOP.
  - PARITY:
    - Expected parity bit is ~^shift_reg when PAR_TYP = 1, and ^shift_reg when PAR_TYP = 0. This matches the transmitter.
    - A mismatch sets a par_fail flag. Go to STOP at edge_cnt = PRESCALE-1.
  - STOP: voted bit 0 sets stp_fail. Go to DONE at edge_cnt = PRESCALE-1.
  - DONE (one cycle):
    - If neither flag is set: P_DATA <= shift_reg and DATA_VALID = 1.
    - Otherwise: PAR_ERR = par_fail, STP_ERR = stp_fail. Both may be 1 together.
    - P_DATA is not updated on error.
    - Next state: START if rx_s = 0 (back-to-back start bit), else IDLE.
- Latency: DATA_VALID fires exactly PRESCALE × (10 + PAR_EN) + 1 CLK cycles after the rx_s falling edge of the start bit.
- Strobe timing: all strobes are registered, high for exactly one cycle, and mutually exclusive with DATA_VALID.
- Frame length: a frame occupies PRESCALE × (10 + PAR_EN) cycles of rx_s. An rx_s = 0 observed in the DONE cycle is treated as the start bit of the next frame.
- Illegal PRESCALE (not 8, 16 or 32): behaviour is undefined; the verification engineer does not check it.

Test Plan:
- PRESCALE = 8, PAR_EN = 1, PAR_TYP = 1, byte 0xA5 sent as line bits 0,1,0,1,0,0,1,0,1,1,1 → exactly one DATA_VALID, P_DATA = 0xA5, PAR_ERR = STP_ERR = 0, latency 89 cycles from the start edge.
- PRESCALE = 16, PAR_EN = 1, PAR_TYP = 0, byte 0x3C with parity bit forced to 1 → PAR_ERR pulses once, no DATA_VALID, P_DATA keeps its previous value.
- PRESCALE = 8, PAR_EN = 0, byte 0x55 with stop bit 0 → STP_ERR pulses once, no DATA_VALID; a following good frame 0x0F gives DATA_VALID with P_DATA = 0x0F.
- PRESCALE = 16: RX_IN low for 3 cycles, then high → returns to IDLE, no strobes, RX_BUSY high for at most 16 cycles.
- PRESCALE = 32, PAR_EN = 0: frames 0x01 and 0xFE back-to-back with no idle gap → two DATA_VALID strobes 320 cycles apart, with P_DATA = 0x01 then 0xFE.
- RST asserted during data bit 3 of a 0x81 frame → all outputs 0 the next cycle, no strobes; after release, frame 0x81 is received correctly.
